// File: rtl/uart_tx_if.sv
// TX FIFO read port as seen by the UART transmit serializer.
// master = serializer (consumer), slave = FIFO memory (producer).
interface uart_tx_if #(
   parameter int unsigned DATASIZE = 8
);
   logic                fifo_empty;
   logic [DATASIZE-1:0] fifo_rdata;
   logic                fifo_rinc;

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      output fifo_rinc
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      input  fifo_rinc
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them as
// start, LSB-first data, optional parity and 1-2 stop bits at a programmable bit period.
module uart_tx #(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned DIVW     = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tx_en,
   input  logic [DIVW-1:0] baud_div,
   input  logic            parity_en,
   input  logic            parity_odd,
   input  logic            stop2,
   uart_tx_if.master       fifo,
   output logic            tx,
   output logic            busy,
   output logic            tx_done
);

   localparam int unsigned BW = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;
   localparam logic [BW-1:0] LastBit = BW'(DATASIZE - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [DIVW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic [DATASIZE-1:0]   shift_q, shift_d;
   logic                  par_q, par_d;
   logic [DIVW-1:0]       div_q, div_d;
   logic                  par_en_q, par_en_d;
   logic                  stop2_q, stop2_d;
   logic                  tx_d, busy_d, done_d;
   logic                  bit_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         div_q    <= '0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         div_q    <= div_d;
         par_en_q <= par_en_d;
         stop2_q  <= stop2_d;
         tx       <= tx_d;
         busy     <= busy_d;
         tx_done  <= done_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bit_d          = bit_q;
      stop_d         = stop_q;
      shift_d        = shift_q;
      par_d          = par_q;
      div_d          = div_q;
      par_en_d       = par_en_q;
      stop2_d        = stop2_q;
      fifo.fifo_rinc = 1'b0;
      bit_end        = (cnt_q == div_q);

      if (state_q != StIdle) begin
         cnt_d = bit_end ? '0 : cnt_q + DIVW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (tx_en && !fifo.fifo_empty) begin
               // Gated with rst_n so no pop can be lost while reset is asserted.
               fifo.fifo_rinc = rst_n;
               shift_d        = fifo.fifo_rdata;
               par_d          = (^fifo.fifo_rdata) ^ parity_odd;
               div_d          = baud_div;
               par_en_d       = parity_en;
               stop2_d        = stop2;
               cnt_d          = '0;
               bit_d          = '0;
               stop_d         = 1'b0;
               state_d        = StStart;
            end
         end
         StStart: begin
            if (bit_end) state_d = StData;
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == LastBit) begin
                  bit_d   = '0;
                  state_d = par_en_q ? StParity : StStop;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         StParity: begin
            if (bit_end) state_d = StStop;
         end
         StStop: begin
            if (bit_end) begin
               if (stop_q == stop2_q) begin
                  stop_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered, so derive them from the next-state values.
      unique case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != StIdle);
      done_d = (state_d == StStop) && (cnt_d == div_d) && (stop_d == stop2_d);
   end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a queue-based FIFO plus a frame-level model
// that predicts the tx waveform, busy, tx_done and pop strobes cycle by cycle.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tx_en = 1'b0;
   logic [15:0] baud_div = '0;
   logic        parity_en = 1'b0;
   logic        parity_odd = 1'b0;
   logic        stop2 = 1'b0;
   logic        tx, busy, tx_done;

   uart_tx_if #(.DATASIZE(8)) fif ();

   uart_tx #(
      .DATASIZE (8),
      .DIVW     (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_en      (tx_en),
      .baud_div   (baud_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .fifo       (fif),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] fq[$];
   logic       expq[$];
   bit         pop_pend = 1'b0;
   int         rinc_cyc[$];
   int         done_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_fifo();
      fif.fifo_empty = (fq.size() == 0);
      fif.fifo_rdata = (fq.size() == 0) ? 8'h00 : fq[0];
   endtask

   // Expected line samples for one frame: each bit repeated baud_div+1 cycles.
   task automatic build_frame(input logic [7:0] d);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (parity_en) bits.push_back((^d) ^ parity_odd);
      bits.push_back(1'b1);
      if (stop2) bits.push_back(1'b1);
      foreach (bits[i]) repeat (int'(baud_div) + 1) expq.push_back(bits[i]);
   endtask

   task automatic monitor();
      logic exp_rinc;
      logic s;
      if (fif.fifo_rinc) rinc_cyc.push_back(cyc);
      if (tx_done) done_cyc.push_back(cyc);
      if (!rst_n) begin
         expq.delete();
         check("rst_rinc", fif.fifo_rinc, 0);
         check("rst_tx", tx, 1);
         check("rst_busy", busy, 0);
         check("rst_done", tx_done, 0);
      end else if (expq.size() == 0) begin
         exp_rinc = tx_en && (fq.size() != 0);
         check("idle_rinc", fif.fifo_rinc, exp_rinc);
         check("idle_tx", tx, 1);
         check("idle_busy", busy, 0);
         check("idle_done", tx_done, 0);
         if (exp_rinc) begin
            build_frame(fq[0]);
            pop_pend = 1'b1;
         end
      end else begin
         s = expq.pop_front();
         check("frame_tx", tx, s);
         check("frame_busy", busy, 1);
         check("frame_done", tx_done, expq.size() == 0);
         check("frame_rinc", fif.fifo_rinc, 0);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      monitor();
      @(posedge clk);
      #1;
      if (pop_pend) begin
         void'(fq.pop_front());
         pop_pend = 1'b0;
      end
      drive_fifo();
   endtask

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      drive_fifo();
   endtask

   task automatic clr();
      rinc_cyc.delete();
      done_cyc.delete();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((expq.size() != 0 || (tx_en && fq.size() != 0)) && n < budget) begin
         tick();
         n++;
      end
      check("drain_complete", (expq.size() == 0) && !(tx_en && fq.size() != 0), 1);
      tick();
   endtask

   function automatic int at(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1000;
   endfunction

   initial begin
      drive_fifo();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Basic 8N1, 0x55, 4-cycle bits
      clr();
      baud_div = 3;
      push(8'h55);
      tx_en = 1'b1;
      drain(200);
      check("basic_pops", rinc_cyc.size(), 1);
      check("basic_dones", done_cyc.size(), 1);
      check("basic_len", at(done_cyc, 0) - at(rinc_cyc, 0), 40);

      // Parity even then odd, 2 stop bits
      for (int odd = 0; odd < 2; odd++) begin
         clr();
         baud_div   = 1;
         parity_en  = 1'b1;
         stop2      = 1'b1;
         parity_odd = odd[0];
         push(8'h07);
         drain(200);
         check("parity_len", at(done_cyc, 0) - at(rinc_cyc, 0), 24);
      end

      // Back-to-back at 1 cycle per bit
      clr();
      baud_div   = 0;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;
      push(8'hA1);
      push(8'h3C);
      push(8'hFF);
      drain(500);
      check("b2b_pops", rinc_cyc.size(), 3);
      check("b2b_dones", done_cyc.size(), 3);
      check("b2b_gap01", at(rinc_cyc, 1) - at(rinc_cyc, 0), 11);
      check("b2b_gap12", at(rinc_cyc, 2) - at(rinc_cyc, 1), 11);

      // Gating: empty FIFO, then tx_en low with data
      clr();
      repeat (10) tick();
      tx_en = 1'b0;
      push(8'h5A);
      repeat (10) tick();
      check("gate_no_pop", rinc_cyc.size(), 0);
      check("gate_kept", fq.size(), 1);

      // Drop tx_en mid-frame: frame completes, no further pop
      baud_div = 2;
      tx_en    = 1'b1;
      repeat (6) tick();
      push(8'h12);
      push(8'h34);
      tx_en = 1'b0;
      drain(500);
      check("drop_pops", rinc_cyc.size(), 1);
      check("drop_dones", done_cyc.size(), 1);
      check("drop_kept", fq.size(), 2);
      fq.delete();
      drive_fifo();

      // Reset during data bit 3
      clr();
      baud_div = 3;
      push(8'hC3);
      tx_en = 1'b1;
      repeat (18) tick();
      rst_n = 1'b0;
      #1;
      check("async_tx", tx, 1);
      check("async_busy", busy, 0);
      check("async_done", tx_done, 0);
      expq.delete();
      push(8'h96);
      repeat (3) tick();
      check("rst_no_done", done_cyc.size(), 0);
      rst_n = 1'b1;
      clr();
      tick();
      check("rst_first_pop", rinc_cyc.size(), 1);
      drain(300);
      check("rst_dones", done_cyc.size(), 1);

      // Divisor change mid-frame
      clr();
      baud_div = 3;
      push(8'h11);
      push(8'h22);
      repeat (13) tick();
      baud_div = 7;
      drain(500);
      check("div_gap", at(rinc_cyc, 1) - at(rinc_cyc, 0), 41);
      check("div_len2", at(done_cyc, 1) - at(rinc_cyc, 1), 80);

      // Randomized frames with config churn mid-frame
      for (int it = 0; it < 25; it++) begin
         int nb;
         int pops0;
         baud_div   = 16'($urandom_range(0, 4));
         parity_en  = 1'($urandom_range(0, 1));
         parity_odd = 1'($urandom_range(0, 1));
         stop2      = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 3);
         pops0 = rinc_cyc.size();
         for (int k = 0; k < nb; k++) push(8'($urandom));
         repeat ($urandom_range(1, 20)) tick();
         baud_div   = 16'($urandom_range(0, 4));
         parity_en  = 1'($urandom_range(0, 1));
         parity_odd = 1'($urandom_range(0, 1));
         stop2      = 1'($urandom_range(0, 1));
         drain(2000);
         check("rand_pops", rinc_cyc.size() - pops0, nb);
      end

      tx_en = 1'b0;
      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
